// File: rtl/rival_car_fsm_pkg.sv
// Shared game constants for the rival car: road geometry, lane table and FSM state encoding.
package rival_car_fsm_pkg;

  localparam logic [9:0] ROAD_LEFT  = 10'd244;
  localparam logic [9:0] ROAD_RIGHT = 10'd318;
  localparam logic [9:0] CAR_W      = 10'd14;
  localparam logic [9:0] CAR_H      = 10'd24;
  localparam logic [9:0] PLAYER_Y   = 10'd400;
  localparam logic [9:0] SCREEN_H   = 10'd480;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;

  // Lanes are inset from the road edges so a rival never overlaps the kerb.
  localparam logic [9:0] LANE_0 = ROAD_LEFT + 10'd4;
  localparam logic [9:0] LANE_1 = LANE_0 + 10'd18;
  localparam logic [9:0] LANE_2 = LANE_0 + 10'd36;
  localparam logic [9:0] LANE_3 = ROAD_RIGHT - CAR_W - 10'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPAWN   = 3'd1,
    ST_DESCEND = 3'd2,
    ST_PASSED  = 3'd3,
    ST_HIT     = 3'd4
  } state_e;

  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    logic [9:0] x;
    case (sel)
      2'd0:    x = LANE_0;
      2'd1:    x = LANE_1;
      2'd2:    x = LANE_2;
      default: x = LANE_3;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/rival_car_fsm_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for lane selection; free-running, non-zero seed.
module rival_lfsr
  import rival_car_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic       fb;

  assign fb = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= LFSR_SEED;
    else       q_q <= {q_q[6:0], fb};
  end

  assign q = q_q;

endmodule

// File: rtl/rival_car_fsm.sv
// Rival car controller: spawns into a random lane, descends on movement ticks,
// scores safe passes and latches a collision with the player car.
module rival_car_fsm
  import rival_car_fsm_pkg::*;
#(
  parameter int TICK_DIV = 3333333,
  parameter int STEP_Y   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       running,
  input  logic       restart,
  input  logic [9:0] current_car_x,
  output logic [9:0] rival_x,
  output logic [9:0] rival_y,
  output logic       rival_collision,
  output logic [7:0] score
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e          state_q;
  logic [9:0]      rival_x_q;
  logic [9:0]      rival_y_q;
  logic [9:0]      rival_y_d;
  logic            collision_q;
  logic [7:0]      score_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic            tick;
  logic [7:0]      lfsr_q;
  logic            unused_lfsr;
  logic [10:0]     rx, ry, cx, y_step;
  logic            overlap;
  logic            at_bottom;

  rival_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:2];

  assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // 11-bit arithmetic keeps x+14 and y+24 from wrapping near the 10-bit limit.
  assign rx = {1'b0, rival_x_q};
  assign ry = {1'b0, rival_y_q};
  assign cx = {1'b0, current_car_x};

  assign overlap = (rx < cx + 11'(CAR_W)) && (cx < rx + 11'(CAR_W)) &&
                   (ry + 11'(CAR_H) > 11'(PLAYER_Y)) &&
                   (ry < 11'(PLAYER_Y) + 11'(CAR_H));

  assign y_step    = ry + 11'(STEP_Y);
  assign at_bottom = (y_step >= 11'(SCREEN_H));
  assign rival_y_d = y_step[9:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rival_x_q   <= '0;
      rival_y_q   <= '0;
      collision_q <= 1'b0;
      score_q     <= '0;
    end else if (restart) begin
      state_q     <= ST_IDLE;
      rival_x_q   <= '0;
      rival_y_q   <= '0;
      collision_q <= 1'b0;
      score_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rival_y_q <= '0;
          if (running) state_q <= ST_SPAWN;
        end
        ST_SPAWN: begin
          rival_x_q <= lane_x(lfsr_q[1:0]);
          rival_y_q <= '0;
          state_q   <= ST_DESCEND;
        end
        ST_DESCEND: begin
          if (overlap) begin
            state_q     <= ST_HIT;
            collision_q <= 1'b1;
          end else if (running && tick) begin
            if (at_bottom) state_q   <= ST_PASSED;
            else           rival_y_q <= rival_y_d;
          end
        end
        ST_PASSED: begin
          if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          state_q <= ST_SPAWN;
        end
        ST_HIT: begin
          state_q <= ST_HIT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rival_x         = rival_x_q;
  assign rival_y         = rival_y_q;
  assign rival_collision = collision_q;
  assign score           = score_q;

endmodule

// File: tb/tb_rival_car_fsm.sv
// Directed bench for rival_car_fsm: lane choice from an LFSR model, descent, pass/score,
// collision geometry table, freeze, restart, async reset and score saturation.
module tb_rival_car_fsm;

  logic       clk;
  logic       reset, running, restart;
  logic [9:0] car_x;
  logic [9:0] rx, ry;
  logic       coll;
  logic [7:0] score;

  logic       reset1, running1, restart1;
  logic [9:0] car_x1;
  logic [9:0] rx1, ry1;
  logic       coll1;
  logic [7:0] score1;

  int checks = 0;
  int errors = 0;

  rival_car_fsm #(.TICK_DIV(4), .STEP_Y(4)) u_dut (
    .clk(clk), .reset(reset), .running(running), .restart(restart),
    .current_car_x(car_x), .rival_x(rx), .rival_y(ry),
    .rival_collision(coll), .score(score)
  );

  // Fast-moving instance so hundreds of passes fit in a short run.
  rival_car_fsm #(.TICK_DIV(2), .STEP_Y(240)) u_fast (
    .clk(clk), .reset(reset1), .running(running1), .restart(restart1),
    .current_car_x(car_x1), .rival_x(rx1), .rival_y(ry1),
    .rival_collision(coll1), .score(score1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value the DUT saw at the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic int lane_of(input logic [7:0] v);
    case (v[1:0])
      2'd0:    return 248;
      2'd1:    return 266;
      2'd2:    return 284;
      default: return 300;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int dx;
    int exp_hit;
    int exp_y;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, last_y, last_chg, steps, bad, t476, t380, lane, last_s;

    vecs[0] = '{dx: -14, exp_hit: 0, exp_y: 476};
    vecs[1] = '{dx: -13, exp_hit: 1, exp_y: 380};
    vecs[2] = '{dx:   0, exp_hit: 1, exp_y: 380};
    vecs[3] = '{dx:  13, exp_hit: 1, exp_y: 380};
    vecs[4] = '{dx:  14, exp_hit: 0, exp_y: 476};

    reset = 1'b1; running = 1'b0; restart = 1'b0; car_x = 10'd200;
    reset1 = 1'b1; running1 = 1'b1; restart1 = 1'b0; car_x1 = 10'd200;
    repeat (3) step();
    chk("reset_x", int'(rx), 0);
    chk("reset_y", int'(ry), 0);
    chk("reset_coll", int'(coll), 0);
    chk("reset_score", int'(score), 0);

    // Reset release: IDLE -> SPAWN -> DESCEND
    running = 1'b1;
    #2 reset = 1'b0;
    step();
    chk("spawn_pending_x", int'(rx), 0);
    step();
    chk("first_spawn_x", int'(rx), lane_of(m_prev));
    chk("first_spawn_y", int'(ry), 0);

    // Full descent with no x-overlap
    car_x = 10'd200;
    cyc = 0; last_y = int'(ry); last_chg = 0; steps = 0; bad = 0; t476 = -1;
    while (score == 8'd0 && cyc < 1000) begin
      step();
      cyc++;
      if (int'(ry) != last_y) begin
        if (int'(ry) != last_y + 4) bad++;
        else if (steps > 0 && cyc - last_chg != 4) bad++;
        steps++;
        last_y = int'(ry);
        last_chg = cyc;
        if (int'(ry) == 476) t476 = cyc;
      end
    end
    chk("pass_in_time", int'(cyc < 1000), 1);
    chk("descent_steps", steps, 119);
    chk("descent_step_shape", bad, 0);
    chk("pass_score", int'(score), 1);
    chk("pass_y", int'(ry), 476);
    chk("pass_latency", cyc - t476, 5);
    step();
    chk("respawn_y", int'(ry), 0);
    chk("respawn_x", int'(rx), lane_of(m_prev));

    // Collision geometry table
    for (int i = 0; i < 5; i++) begin
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_x", int'(rx), 0);
      chk("restart_y", int'(ry), 0);
      chk("restart_coll", int'(coll), 0);
      chk("restart_score", int'(score), 0);
      step();
      step();
      lane = lane_of(m_prev);
      chk("vec_lane", int'(rx), lane);
      car_x = 10'(lane + vecs[i].dx);
      cyc = 0; t380 = -1;
      while (coll == 1'b0 && score == 8'd0 && cyc < 1000) begin
        step();
        cyc++;
        if (int'(ry) == 380 && t380 < 0) t380 = cyc;
      end
      chk("vec_done", int'(cyc < 1000), 1);
      chk("vec_coll", int'(coll), vecs[i].exp_hit);
      chk("vec_y", int'(ry), vecs[i].exp_y);
      if (vecs[i].exp_hit != 0) begin
        chk("hit_latency", cyc - t380, 1);
        bad = 0;
        repeat (20) begin
          step();
          if (ry != 10'd380 || coll != 1'b1 || score != 8'd0 || rx != 10'(lane)) bad++;
        end
        chk("hit_hold", bad, 0);
      end
    end

    // running=0 keeps IDLE
    restart = 1'b1; running = 1'b0;
    step();
    restart = 1'b0;
    repeat (10) step();
    chk("idle_hold_x", int'(rx), 0);
    chk("idle_hold_y", int'(ry), 0);
    running = 1'b1;
    step();
    step();
    chk("idle_release_x", int'(rx), lane_of(m_prev));

    // Freeze at y=100 and resume
    car_x = 10'd200;
    cyc = 0;
    while (ry != 10'd100 && cyc < 1000) begin step(); cyc++; end
    chk("reach_100", int'(ry), 100);
    running = 1'b0;
    bad = 0;
    repeat (50) begin
      step();
      if (ry != 10'd100) bad++;
    end
    chk("freeze_hold", bad, 0);
    running = 1'b1;
    cyc = 0;
    while (ry == 10'd100 && cyc < 20) begin step(); cyc++; end
    chk("resume_y", int'(ry), 104);

    // Asynchronous reset mid-descent
    cyc = 0;
    while (ry != 10'd200 && cyc < 1000) begin step(); cyc++; end
    chk("reach_200", int'(ry), 200);
    #2 reset = 1'b1;
    #1;
    chk("async_x", int'(rx), 0);
    chk("async_y", int'(ry), 0);
    chk("async_coll", int'(coll), 0);
    chk("async_score", int'(score), 0);
    #2 reset = 1'b0;
    step();
    step();
    chk("post_reset_lane", int'(rx), lane_of(m_prev));

    // Score saturation on the fast instance
    reset1 = 1'b0;
    last_s = 0; bad = 0; steps = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (int'(score1) != last_s) begin
        if (int'(score1) != last_s + 1) bad++;
        last_s = int'(score1);
      end
      if (score1 == 8'hFF) steps++;
    end
    chk("sat_score", int'(score1), 255);
    chk("sat_monotone", bad, 0);
    chk("sat_held_long", int'(steps > 1000), 1);
    chk("sat_no_coll", int'(coll1), 0);
    chk("sat_x_on_road", int'(rx1 >= 10'd248 && rx1 <= 10'd300), 1);
    chk("sat_y_range", int'(ry1 <= 10'd240), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rival_car_fsm.md
RIVAL_CAR_FSM -- requirements
Module: rival_car_fsm

Interface
REQ-001 Parameter TICK_DIV, default 3333333, clk cycles per movement tick (30 Hz at 100 MHz).
REQ-002 Parameter STEP_Y, default 4, pixels rival descends per tick.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 running  input  1  player game-active flag; 0 freezes rival motion.
REQ-006 restart  input  1  synchronous game restart (centre button), level-sensitive.
REQ-007 current_car_x  input  10  player car left-edge x, registered upstream.
REQ-008 rival_x  output  10  rival car left-edge x.
REQ-009 rival_y  output  10  rival car top-edge y.
REQ-010 rival_collision  output  1  rival/player overlap flag, held until restart.
REQ-011 score  output  8  count of rivals passed safely.

Function
REQ-012 States SHALL be IDLE, SPAWN, DESCEND, PASSED, HIT.
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 free-running; tick SHALL be high for one cycle when count == TICK_DIV-1.
REQ-014 IDLE -> SPAWN when running=1 and restart=0; otherwise IDLE holds, rival_y=0.
REQ-015 SPAWN SHALL last one cycle: rival_x <= LANE[lfsr[1:0]] with LANE = {248, 266, 284, 300}, rival_y <= 0, then -> DESCEND.
REQ-016 Geometry: both cars 14 wide, 24 tall; player top y fixed at 400.
REQ-017 Overlap = (rival_x < current_car_x+14) and (current_car_x < rival_x+14) and (rival_y+24 > 400) and (rival_y < 424), evaluated combinationally from registered values, 11-bit unsigned compares.
REQ-018 DESCEND priority, highest first: overlap -> HIT; running=0 -> hold all registers; tick and rival_y+STEP_Y >= 480 -> PASSED; tick -> rival_y += STEP_Y.
REQ-019 PASSED SHALL last one cycle: score += 1, saturating at 255, then -> SPAWN.
REQ-020 HIT SHALL set rival_collision=1 on the same edge the state enters HIT, and SHALL hold state, position and flag until restart.
REQ-021 Overlap-to-rival_collision latency SHALL be exactly one clk edge.
REQ-022 restart=1 in any state SHALL synchronously force IDLE, rival_y=0, rival_x=0, rival_collision=0, score=0, and SHALL take priority over every transition.
REQ-023 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, SHALL advance every clk cycle, independent of state and running.
REQ-024 running falling mid-DESCEND SHALL freeze rival_y; rising again SHALL resume from the frozen value.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, tick counter 0, rival_x=0, rival_y=0, rival_collision=0, score=0, LFSR=8'hA5.
REQ-026 reset asserted mid-DESCEND or in HIT SHALL return to IDLE with all outputs at reset values within the same cycle.
REQ-027 LFSR SHALL never reach all-zero.

Structure
REQ-028 A shared game package SHALL hold road limits (244, 318), car width 14, car height 24, player top y 400, screen height 480, the LANE table and the state encoding.
REQ-029 The LFSR SHALL be a sub-module named rival_lfsr with ports clk, reset, q[7:0].
REQ-030 Outputs SHALL be driven directly from registers.

Verification (TICK_DIV=4, STEP_Y=4)
REQ-031 Reset release with running=1, restart=0 -> IDLE, then SPAWN, then DESCEND; rival_x in LANE table; rival_y=0.
REQ-032 current_car_x=200 (no x-overlap), running=1 -> rival_y steps 0,4,...,476; on the next tick PASSED; score=1; then re-SPAWN.
REQ-033 current_car_x=rival_x, rival_y reaches 380 (380+24>400) -> rival_collision=1 one edge later; rival_y holds at 380 for 20 cycles.
REQ-034 running=0 at rival_y=100 for 50 cycles -> rival_y stays 100; running=1 -> next tick gives 104.
REQ-035 In HIT, pulse restart for 1 cycle -> rival_collision=0, score=0, IDLE, then SPAWN on the next cycle.
REQ-036 Assert reset asynchronously mid-DESCEND at rival_y=200 -> all outputs 0 before the next clk edge; 300 passes with no collision -> score saturates at 255.
